// File: rtl/csa_resolver_pkg.sv
// Shared definitions for the carry-save resolver: FSM encoding and the
// multiplier-wide default datapath width.
package csa_resolver_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    RES_IDLE = 2'd0,
    RES_BUSY = 2'd1,
    RES_DONE = 2'd2
  } res_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/slice_adder.sv
// Combinational SLICE-bit ripple adder built from full_adder cells:
// {cout, s} = a + b + cin.
module slice_adder #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save (sum, carry) pair to binary, one SLICE-bit chunk per
// clock, behind valid/ready handshakes on both sides.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       hi
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  res_state_e state_q, state_d;

  logic [NSLICE-1:0][SLICE-1:0] s_q, c_q, res_q;
  logic                         ctop_q;
  logic [IDXW-1:0]              idx_q;
  logic                         cy_q;
  logic [1:0]                   hi_q;

  logic             accept;
  logic             last;
  logic [SLICE-1:0] sl_sum;
  logic             sl_cout;

  assign accept = in_valid & in_ready;
  assign last   = (idx_q == LAST_IDX);

  slice_adder #(
    .SLICE (SLICE)
  ) u_slice_adder (
    .a    (s_q[idx_q]),
    .b    (c_q[idx_q]),
    .cin  (cy_q),
    .s    (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RES_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RES_IDLE: if (in_valid) state_d = RES_BUSY;
      RES_BUSY: if (last) state_d = RES_DONE;
      // Completing handshake and a new operand in the same cycle skips IDLE.
      RES_DONE: if (out_ready) state_d = in_valid ? RES_BUSY : RES_IDLE;
      default:  state_d = RES_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      RES_IDLE: in_ready = 1'b1;
      RES_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      c_q    <= '0;
      ctop_q <= 1'b0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      res_q  <= '0;
      hi_q   <= '0;
    end else if (accept) begin
      s_q    <= sum_in;
      c_q    <= {carry_in[WIDTH-2:0], 1'b0};
      ctop_q <= carry_in[WIDTH-1];
      idx_q  <= '0;
      cy_q   <= 1'b0;
    end else if (state_q == RES_BUSY) begin
      res_q[idx_q] <= sl_sum;
      cy_q         <= sl_cout;
      idx_q        <= last ? '0 : idx_q + 1'b1;
      // The carry bit shifted out of the top lands at weight 2^WIDTH.
      if (last) hi_q <= {1'b0, sl_cout} + {1'b0, ctop_q};
    end
  end

  assign result = res_q;
  assign hi     = hi_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: accepted operands push a reference
// sum + 2*carry into a queue; a monitor pops and compares on each output handshake.
module tb_csa_resolver;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SLICE  = 16;
  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned VW     = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0]       hi;

  csa_resolver #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] val;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            hs_cyc[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;
  logic          ov_prev = 1'b0;
  logic          stop_toggle;
  logic [VW-1:0] exp_a;

  function automatic logic [VW-1:0] ref_model(input logic [WIDTH-1:0] s,
                                              input logic [WIDTH-1:0] c);
    return VW'(s) + (VW'(c) << 1);
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reset discards any pending operands.
  always @(negedge rst_n) sb_q.delete();

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid && !ov_prev && sb_q.size() != 0)
        chk("latency", VW'(cyc - sb_q[0].cyc), VW'(NSLICE + 1));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_output: got %h, want no output", {hi, result});
        end else begin
          mon_e = sb_q.pop_front();
          chk("result_hi", {hi, result}, mon_e.val);
          hs_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) sb_q.push_back('{ref_model(sum_in, carry_in), cyc});
      ov_prev <= out_valid;
    end
  end

  task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    bit ok = 1'b0;
    in_valid = 1'b1;
    sum_in   = s;
    carry_in = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    #1 chk("drain", VW'(sb_q.size()), '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_in    = '0;
    carry_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", VW'(out_valid), '0);
    chk("reset_in_ready", VW'(in_ready), VW'(1));
    chk("reset_result", VW'(result), '0);
    chk("reset_hi", VW'(hi), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: small values, full-width overflow, slice-boundary carry.
    send(64'h5, 64'h3);
    drain();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    send(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_8000);
    drain();

    // DONE held by out_ready=0 while a new operand waits.
    out_ready = 1'b0;
    exp_a = ref_model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    in_valid = 1'b1;
    sum_in   = 64'hDEAD_BEEF_0000_FFFF;
    carry_in = 64'h8000_0000_FFFF_0001;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("hold_out_valid", VW'(out_valid), VW'(1));
      chk("hold_result", VW'(result), VW'(exp_a[WIDTH-1:0]));
      chk("hold_hi", VW'(hi), VW'(exp_a[VW-1:WIDTH]));
      chk("hold_in_ready", VW'(in_ready), '0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("same_edge_accept", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Back-to-back stream: one result every NSLICE+1 cycles.
    hs_cyc.delete();
    repeat (3) send({$urandom, $urandom}, {$urandom, $urandom});
    drain();
    chk("stream_count", VW'(hs_cyc.size()), VW'(3));
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("stream_gap", VW'(hs_cyc[i] - hs_cyc[i-1]), VW'(NSLICE + 1));

    // Reset while BUSY at idx=2 drops the operand.
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", VW'(out_valid), '0);
    chk("midrst_in_ready", VW'(in_ready), VW'(1));
    chk("midrst_result", VW'(result), '0);
    chk("midrst_hi", VW'(hi), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    drain();

    // Random operands with random downstream back-pressure.
    stop_toggle = 1'b0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          if (n % 5 == 0) send('1, {$urandom, $urandom});
          else send({$urandom, $urandom}, {$urandom, $urandom});
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        stop_toggle = 1'b1;
      end
      begin
        while (!stop_toggle) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
